// File: rtl/call_sync_server.sv
// Two-phase handshake server behind the call arbiter: synchronizes req_i, issues a start pulse,
// acks on done_i. Optional watchdog enabled by defining CALL_SRV_TIMEOUT_EN.
module call_sync_server #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    output logic             ack_o,
    output logic             start_o,
    input  logic             done_i,
    output logic             busy_o,
    output logic             err_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] count_o
);

    typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   req_seen_q, req_seen_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   tmo_hit;

    assign req_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d    = state_q;
        req_seen_d = req_seen_q;
        ack_d      = ack_q;
        err_d      = err_q;
        count_d    = count_q;
        // Any phase change while a request is in flight is a protocol violation.
        if (state_q != StIdle && req_s != req_seen_q) begin
            err_d = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (req_s != req_seen_q) begin
                    state_d    = StStart;
                    req_seen_d = req_s;
                end
            end
            StStart, StWait: begin
                if (done_i) begin
                    state_d    = StIdle;
                    ack_d      = ~ack_q;
                    count_d    = count_q + CNT_W'(1);
                    req_seen_d = req_s;
                end else if (tmo_hit) begin
                    state_d    = StIdle;
                    ack_d      = ~ack_q;
                    req_seen_d = req_s;
                end else begin
                    state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sync_q     <= '0;
            req_seen_q <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], req_i};
            req_seen_q <= req_seen_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

`ifdef CALL_SRV_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            timeout_q, timeout_d;

    assign tmo_hit = (state_q != StIdle) && (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = timeout_q;
        // Zero while idle so the count is 0 in the START cycle.
        if (state_q == StIdle) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
        if (tmo_hit && !done_i) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign tmo_hit   = 1'b0;
    // Constant 0 for every legal TIMEOUT_CYC.
    assign timeout_o = (TIMEOUT_CYC == 0);
`endif

    assign ack_o   = ack_q;
    assign start_o = (state_q == StStart);
    assign busy_o  = (state_q != StIdle);
    assign err_o   = err_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_call_sync_server.sv
// Directed-plus-random bench for call_sync_server against a transaction-level model.
module tb_call_sync_server;

    localparam int unsigned S  = 2;
    localparam int unsigned CW = 4;
    localparam int unsigned TC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_i;
    logic          done_i;
    logic          ack_o;
    logic          start_o;
    logic          busy_o;
    logic          err_o;
    logic          timeout_o;
    logic [CW-1:0] count_o;

    call_sync_server #(
        .SYNC_STAGES (S),
        .CNT_W       (CW),
        .TIMEOUT_CYC (TC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .ack_o     (ack_o),
        .start_o   (start_o),
        .done_i    (done_i),
        .busy_o    (busy_o),
        .err_o     (err_o),
        .timeout_o (timeout_o),
        .count_o   (count_o)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err    = 0;
    // Transaction-level model: ack parity, completed count, sticky flags, request phase.
    logic exp_ack  = 1'b0;
    int   exp_cnt  = 0;
    logic exp_err  = 1'b0;
    logic exp_tmo  = 1'b0;
    logic phase    = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic exp_busy, input logic exp_start);
        check({tag, ".ack"}, 32'(ack_o), 32'(exp_ack));
        check({tag, ".count"}, 32'(count_o), 32'(exp_cnt));
        check({tag, ".err"}, 32'(err_o), 32'(exp_err));
        check({tag, ".timeout"}, 32'(timeout_o), 32'(exp_tmo));
        check({tag, ".busy"}, 32'(busy_o), 32'(exp_busy));
        check({tag, ".start"}, 32'(start_o), 32'(exp_start));
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req_i  = 1'b0;
        done_i = 1'b0;
        step();
        exp_ack = 1'b0;
        exp_cnt = 0;
        exp_err = 1'b0;
        exp_tmo = 1'b0;
        phase   = 1'b0;
        check_state("reset", 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // New request phase; start_o must appear exactly S+1 cycles later.
    task automatic to_start();
        phase = ~phase;
        req_i = phase;
        repeat (S) begin
            step();
            check_state("sync", 1'b0, 1'b0);
        end
        step();
        check_state("start", 1'b1, 1'b1);
    endtask

    task automatic complete();
        done_i = 1'b1;
        step();
        done_i  = 1'b0;
        exp_ack = ~exp_ack;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        check_state("done", 1'b0, 1'b0);
    endtask

    task automatic finish_txn(input int d);
        repeat (d) begin
            step();
            check_state("wait", 1'b1, 1'b0);
        end
        complete();
    endtask

    initial begin
        rst    = 1'b1;
        req_i  = 1'b0;
        done_i = 1'b0;
        repeat (3) step();
        do_reset();

        // Single request, done three cycles after start.
        to_start();
        finish_txn(3);

        // Ten same-cycle completions from a clean reset: ack ends at 0, count 10.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            to_start();
            finish_txn(0);
        end
        check("ten.ack_final", 32'(ack_o), 32'd0);
        check("ten.count_final", 32'(count_o), 32'd10);

        // Randomized gaps and service latencies; 20 transactions wrap the 4-bit counter.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) begin
                step();
                check_state("gap", 1'b0, 1'b0);
            end
            to_start();
            finish_txn(int'($urandom_range(0, 5)));
        end
        check("wrap.count", 32'(count_o), 32'd4);

        // Violation: two toggles during WAIT, then done; no extra start afterwards.
        do_reset();
        to_start();
        step();
        req_i = ~req_i;
        step();
        req_i = ~req_i;
        repeat (S + 1) step();
        exp_err = 1'b1;
        check_state("viol2", 1'b1, 1'b0);
        complete();
        repeat (S + 3) begin
            step();
            check_state("viol2.idle", 1'b0, 1'b0);
        end

        // Violation with a single toggle: the new phase is absorbed at completion.
        to_start();
        step();
        phase = ~phase;
        req_i = phase;
        repeat (S + 1) step();
        check_state("viol1", 1'b1, 1'b0);
        complete();
        repeat (S + 3) begin
            step();
            check_state("viol1.idle", 1'b0, 1'b0);
        end

        // Watchdog: no done_i after a fresh start.
        to_start();
`ifdef CALL_SRV_TIMEOUT_EN
        repeat (TC - 1) begin
            step();
            check_state("tmo.wait", 1'b1, 1'b0);
        end
        step();
        exp_ack = ~exp_ack;
        exp_tmo = 1'b1;
        check_state("tmo.fire", 1'b0, 1'b0);
        to_start();
        step();
`else
        repeat (100) begin
            step();
            check_state("no_tmo", 1'b1, 1'b0);
        end
`endif

        // Reset while in WAIT, then a normal transaction.
        do_reset();
        to_start();
        finish_txn(2);
        check("post_rst.count", 32'(count_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
